data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter LEN_W, default 4, DMA burst-length field width (bursts of 1..2^LEN_W beats).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cpu_req  input  1  CPU single-access request, held until cpu_gnt seen.
REQ-007 cpu_we  input  1  CPU access is write (1) or read (0); stable while cpu_req.
REQ-008 cpu_addr  input  ADDR_W  CPU word address; stable while cpu_req.
REQ-009 cpu_wdata  input  DATA_W  CPU write data; stable while cpu_req.
REQ-010 cpu_gnt  output  1  high in the single cycle the CPU access drives the memory.
REQ-011 cpu_rvalid  output  1  CPU read data valid, one-cycle pulse.
REQ-012 cpu_rdata  output  DATA_W  registered CPU read data.
REQ-013 dma_req  input  1  DMA burst request, held until first dma_gnt.
REQ-014 dma_we  input  1  burst direction; sampled at burst start.
REQ-015 dma_addr  input  ADDR_W  burst start address; sampled at burst start.
REQ-016 dma_len  input  LEN_W  beats minus one; sampled at burst start.
REQ-017 dma_wdata  input  DATA_W  write data for the current beat, valid whenever dma_gnt high.
REQ-018 dma_gnt  output  1  high in every burst beat cycle.
REQ-019 dma_rvalid  output  1  DMA read beat data valid, one-cycle pulse per read beat.
REQ-020 dma_rdata  output  DATA_W  registered DMA read beat data.
REQ-021 dma_done  output  1  one-cycle pulse in the cycle after the final burst beat.
REQ-022 wr_en_mem  output  1  memory write enable.
REQ-023 add_mem  output  ADDR_W  memory address.
REQ-024 wrd_mem  output  DATA_W  memory write data.
REQ-025 rdd_mem  input  DATA_W  memory combinational read data for add_mem.

Function
REQ-026 SHALL implement registered FSM states IDLE, CPU, DMA; memory outputs decoded from current state.
REQ-027 IDLE: wr_en_mem=0, add_mem=0, wrd_mem=0, no grants.
REQ-028 CPU state: cpu_gnt=1, add_mem=cpu_addr, wrd_mem=cpu_wdata, wr_en_mem=cpu_we; state lasts exactly one cycle.
REQ-029 DMA state: dma_gnt=1, add_mem=base+beat (modulo 2^ADDR_W), wrd_mem=dma_wdata, wr_en_mem=latched we; beat counter starts 0, increments each DMA cycle.
REQ-030 Base address, direction and length SHALL be latched in the cycle the FSM transitions into DMA from a non-DMA state.
REQ-031 Burst SHALL last exactly latched_len+1 consecutive cycles, never interrupted by cpu_req.
REQ-032 Next state when not mid-burst: eligible_cpu = cpu_req and state!=CPU; eligible_dma = dma_req and not (DMA on last beat); neither -> IDLE; one -> that requester.
REQ-033 Both eligible -> round-robin: grant the requester not granted most recently; last-winner register updates on each new grant.
REQ-034 A requester SHALL NOT be re-granted in the cycle immediately after its own grant completes (minimum one non-grant cycle between its accesses).
REQ-035 Read capture: cpu_rdata/dma_rdata load rdd_mem at end of a read grant cycle; matching rvalid high the following cycle only; writes produce no rvalid.
REQ-036 dma_done SHALL pulse the cycle after the last beat, coincident with the last beat's dma_rvalid for reads.
REQ-037 Grant latency: req asserted in cycle T with no contention -> grant in cycle T+1.
REQ-038 Worst-case CPU wait SHALL be 2^LEN_W + 1 cycles from cpu_req to cpu_gnt.

Reset
REQ-039 rst high at a clock edge SHALL force state IDLE, beat counter 0, last-winner=DMA (CPU wins first tie), all grant/rvalid/done outputs 0, rdata registers 0.
REQ-040 rst during a burst SHALL abort it: no further beats, no dma_done, no pending rvalid after reset.

Verification
REQ-041 CPU write addr 5 data 0xA5A5A5A5, later CPU read addr 5 -> cpu_gnt one cycle each, read gives cpu_rvalid next cycle with cpu_rdata 0xA5A5A5A5.
REQ-042 DMA write dma_addr 0x10, dma_len 3, wdata 1,2,3,4 -> dma_gnt 4 cycles, addresses 0x10..0x13, dma_done cycle after; DMA read same range returns 1..4 with 4 rvalid pulses.
REQ-043 cpu_req and dma_req rise together after reset -> CPU granted first, DMA next; repeat with both held -> grants alternate.
REQ-044 cpu_req raised in beat 1 of 16-beat burst (dma_len 15) -> cpu_gnt in cycle after beat 15, before any new DMA grant.
REQ-045 DMA burst at dma_addr 0xFFFFFFFE, dma_len 3 -> add_mem 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-046 rst asserted at beat 2 of 8-beat read burst -> next cycle all outputs 0, no dma_done, no dma_rvalid.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter sharing one memory port between CPU single accesses and DMA bursts.
module data_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              wr_en_mem,
    output logic [ADDR_W-1:0] add_mem,
    output logic [DATA_W-1:0] wrd_mem,
    input  logic [DATA_W-1:0] rdd_mem
);
    typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;
    state_t state, state_n;
    logic [LEN_W-1:0] beat, len;
    logic [ADDR_W-1:0] base;
    logic we_l, last_dma, last_beat, elig_cpu, elig_dma;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // A requester whose grant is just finishing is not eligible, which forces a gap between its accesses.
    always_comb begin
        last_beat = state == DMA && beat == len;
        elig_cpu = cpu_req && state != CPU;
        elig_dma = dma_req && !last_beat;
        state_n = (state == DMA && !last_beat) ? DMA :
                  (elig_cpu && elig_dma) ? (last_dma ? CPU : DMA) :
                  elig_cpu ? CPU : elig_dma ? DMA : IDLE;
        cpu_gnt = state == CPU;
        dma_gnt = state == DMA;
        wr_en_mem = cpu_gnt ? cpu_we : dma_gnt && we_l;
        add_mem = cpu_gnt ? cpu_addr : dma_gnt ? base + ADDR_W'(beat) : '0;
        wrd_mem = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
            len <= '0;
            base <= '0;
            we_l <= 1'b0;
            last_dma <= 1'b1;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_done <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dma_rvalid <= dma_gnt && !we_l;
            dma_done <= last_beat;
            if (cpu_gnt && !cpu_we) cpu_rdata <= rdd_mem;
            if (dma_gnt && !we_l) dma_rdata <= rdd_mem;
            if (state_n == CPU) last_dma <= 1'b0;
            if (state_n == DMA && state != DMA) begin
                last_dma <= 1'b1;
                base <= dma_addr;
                len <= dma_len;
                we_l <= dma_we;
            end
            beat <= (state_n == DMA && state == DMA) ? beat + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench; a transaction-level model predicts grant cycles, memory traffic and read returns.
module tb_data_mem_arbiter;
    logic clk = 0;
    logic rst = 1;
    logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata;
    logic [3:0] dma_len = 0;
    logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, dma_done, wr_en_mem;
    logic [31:0] cpu_rdata, dma_rdata, add_mem, wrd_mem, rdd_mem;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata), .dma_done(dma_done),
        .wr_en_mem(wr_en_mem), .add_mem(add_mem), .wrd_mem(wrd_mem), .rdd_mem(rdd_mem)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; bit dma; logic [31:0] addr; bit we; logic [31:0] wdata;} gnt_t;
    typedef struct {int cyc; bit dma; bit rv; logic [31:0] data; bit done;} out_t;
    gnt_t gnt_q[$];
    out_t out_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit last_dma = 1;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] burst_data [16];
    logic [3:0] tb_beat = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (wr_en_mem) mem[add_mem[7:0]] <= wrd_mem;
    always @(posedge clk) tb_beat <= dma_gnt ? tb_beat + 4'd1 : 4'd0;
    assign rdd_mem = mem[add_mem[7:0]];
    assign dma_wdata = burst_data[tb_beat];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        gnt_t g;
        out_t o;
        logic [31:0] rd;
        if (started) begin
            if (cpu_gnt && dma_gnt) check("both_gnt", 1, 0);
            if (cpu_gnt || dma_gnt) begin
                if (gnt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_gnt at cycle %0d: cpu_gnt %b dma_gnt %b add_mem %h", cyc, cpu_gnt, dma_gnt, add_mem);
                end else begin
                    g = gnt_q.pop_front();
                    check("grant", {cyc, cpu_gnt, dma_gnt, add_mem, wr_en_mem, wrd_mem},
                          {g.cyc, !g.dma, g.dma, g.addr, g.we, g.wdata});
                end
            end else check("idle_mem", {wr_en_mem, add_mem, wrd_mem}, '0);
            if (cpu_rvalid || dma_rvalid || dma_done) begin
                rd = cpu_rvalid ? cpu_rdata : dma_rvalid ? dma_rdata : '0;
                if (out_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out at cycle %0d: cpu_rvalid %b dma_rvalid %b dma_done %b", cyc, cpu_rvalid, dma_rvalid, dma_done);
                end else begin
                    o = out_q.pop_front();
                    check("read_out", {cyc, cpu_rvalid, dma_rvalid, dma_done, rd},
                          {o.cyc, !o.dma && o.rv, o.dma && o.rv, o.done, o.rv ? o.data : 32'h0});
                end
            end
        end
    end

    task automatic push_cpu(input int g, input bit we, input logic [31:0] a, input logic [31:0] d);
        gnt_q.push_back('{g, 1'b0, a, we, d});
        if (we) ref_mem[a[7:0]] = d;
        else out_q.push_back('{g + 1, 1'b0, 1'b1, ref_mem[a[7:0]], 1'b0});
    endtask

    // nb limits how many beats happen (a reset cuts the burst short and swallows its pending read return)
    task automatic push_dma(input int g, input bit we, input logic [31:0] a, input int len, input int nb);
        logic [31:0] ak;
        for (int k = 0; k < nb; k++) begin
            ak = a + 32'(k);
            gnt_q.push_back('{g + k, 1'b1, ak, we, burst_data[k]});
            if (we) ref_mem[ak[7:0]] = burst_data[k];
            if (k + 1 < nb || nb == len + 1) begin
                if (!we) out_q.push_back('{g + k + 1, 1'b1, 1'b1, ref_mem[ak[7:0]], k == len});
                else if (k == len) out_q.push_back('{g + k + 1, 1'b1, 1'b0, 32'h0, 1'b1});
            end
        end
    endtask

    // d: cycles between dma_req and cpu_req when both are used (0 = simultaneous)
    task automatic round(input bit ce, input bit cwe, input logic [31:0] ca, input logic [31:0] cd,
                         input bit de, input bit dwe, input logic [31:0] da, input int dl,
                         input int d, input int gap);
        int t, gc, gd, last;
        bit cpu_first;
        t = cyc;
        gc = -10;
        gd = -10;
        cpu_first = ce;
        if (ce && de) begin
            cpu_first = d == 0 && last_dma;
            if (cpu_first) begin gc = t + 1; gd = t + 2; end
            else begin
                gd = t + 1;
                gc = (t + d + 1 > t + dl + 2) ? t + d + 1 : t + dl + 2;
            end
        end else if (ce) gc = t + 1;
        else if (de) gd = t + 1;
        if (ce && !cpu_first) last_dma = 0;
        else if (de) last_dma = 1;
        else last_dma = 0;
        if (cpu_first) push_cpu(gc, cwe, ca, cd);
        if (de) push_dma(gd, dwe, da, dl, dl + 1);
        if (ce && !cpu_first) push_cpu(gc, cwe, ca, cd);
        last = gc > gd + dl ? gc : gd + dl;
        cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        cpu_req = ce && (d == 0 || !de);
        dma_we = dwe; dma_addr = da; dma_len = 4'(dl);
        dma_req = de;
        while (cyc < last + 1 + gap) begin
            @(posedge clk); #1;
            if (ce && de && d > 0 && cyc == t + d) cpu_req = 1;
            if (cyc == gc + 1) begin cpu_req = 0; cpu_addr = $urandom; end
            if (cyc == gd + 1) begin
                dma_req = 0; dma_addr = $urandom; dma_len = 4'($urandom); dma_we = 1'($urandom);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        bit ce, de;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
            ref_mem[i] = mem[i];
        end
        for (int k = 0; k < 16; k++) burst_data[k] = $urandom;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_outputs", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, dma_done, wr_en_mem, add_mem, wrd_mem, cpu_rdata, dma_rdata}, '0);
        started = 1;
        @(posedge clk); #1;
        round(1, 1, 32'h20, 32'hDEAD0001, 1, 1, 32'h30, 1, 0, 0);
        round(1, 0, 32'h30, 32'h0, 1, 0, 32'h20, 0, 0, 1);
        round(1, 1, 32'h5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 2);
        round(1, 0, 32'h5, 32'h0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) burst_data[k] = 32'(k + 1);
        round(0, 0, 0, 0, 1, 1, 32'h10, 3, 0, 1);
        for (int k = 0; k < 4; k++) burst_data[k] = 32'hCC00 + 32'(k);
        round(0, 0, 0, 0, 1, 0, 32'h10, 3, 0, 1);
        round(0, 0, 0, 0, 1, 0, 32'hFFFFFFFE, 3, 0, 1);
        for (int k = 0; k < 16; k++) burst_data[k] = $urandom;
        round(1, 0, 32'h5, 32'h0, 1, 1, 32'h80, 15, 2, 1);
        // abort an 8-beat read burst with reset during its third beat
        t = cyc;
        push_dma(t + 1, 0, 32'h40, 7, 3);
        dma_we = 0; dma_addr = 32'h40; dma_len = 4'd7; dma_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1 dma_req = 0;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        last_dma = 1;
        @(negedge clk);
        check("abort_outputs", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, dma_done, wr_en_mem, add_mem, wrd_mem, cpu_rdata, dma_rdata}, '0);
        repeat (10) @(posedge clk);
        #1;
        round(1, 1, 32'h7, 32'h12345678, 1, 0, 32'h7, 2, 0, 0);
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 16; k++) burst_data[k] = $urandom;
            ce = 1'($urandom);
            de = ce ? 1'($urandom) : 1'b1;
            round(ce, 1'($urandom), 32'($urandom_range(0, 63)), $urandom,
                  de, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63)),
                  $urandom_range(0, 15), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 18) : 0,
                  $urandom_range(0, 2));
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("gnt_queue_drained", 160'(gnt_q.size()), 0);
        check("out_queue_drained", 160'(out_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
